div_4bits: RTL

//   Sequential restoring divider; the inverse of the 4-bit multiplier. Divides a 2*BITS-bit

---
 rtl/div_4bits.sv | 119 +++++++++++
 1 files changed

// File: rtl/div_4bits.sv
// rtl/div_4bits.sv - sequential restoring divider, 2*BITS-bit dividend by BITS-bit divisor
module div_4bits #(
  parameter int BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [2*BITS-1:0]   Dividend,
  input  logic [BITS-1:0]     Divisor,
  output logic                busy,
  output logic                done,
  output logic [2*BITS-1:0]   Quotient_o,
  output logic [BITS-1:0]     Remainder_o,
  output logic                div_zero_o
);

  localparam int CW = $clog2(2*BITS+1);
  localparam logic [CW-1:0] STEPS = CW'(2*BITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [2*BITS-1:0]   r_qsh;
  logic [BITS:0]       r_prem;
  logic [BITS-1:0]     r_div;
  logic [CW-1:0]       r_cnt;

  logic [BITS:0]       w_shift;
  logic [BITS:0]       w_div_ext;
  logic [BITS:0]       w_sub;
  logic                w_ge;
  logic [BITS:0]       w_prem_next;
  logic [2*BITS-1:0]   w_qsh_next;

  // One restoring step: shift {prem, qsh} left, subtract divisor when it fits.
  // The bit shifted out of prem's top also counts as "fits", which keeps the
  // compare correct without widening the datapath.
  always_comb begin
    w_shift     = {r_prem[BITS-1:0], r_qsh[2*BITS-1]};
    w_div_ext   = {1'b0, r_div};
    w_sub       = w_shift - w_div_ext;
    w_ge        = r_prem[BITS] | (w_shift >= w_div_ext);
    w_prem_next = w_ge ? w_sub : w_shift;
    w_qsh_next  = {r_qsh[2*BITS-2:0], w_ge};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state and handshake outputs; divide-by-zero skips CALC entirely.
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state != S_IDLE);
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = (Divisor == '0) ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (r_cnt == '0) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, iterate in CALC, publish results on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_qsh       <= '0;
      r_prem      <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      Quotient_o  <= '0;
      Remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_qsh  <= Dividend;
            r_div  <= Divisor;
            r_prem <= '0;
            r_cnt  <= STEPS;
            if (Divisor == '0) begin
              Quotient_o  <= '1;
              Remainder_o <= Dividend[BITS-1:0];
              div_zero_o  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          if (r_cnt != '0) begin
            r_qsh  <= w_qsh_next;
            r_prem <= w_prem_next;
            r_cnt  <= r_cnt - CW'(1);
          end else begin
            Quotient_o  <= r_qsh;
            Remainder_o <= r_prem[BITS-1:0];
            div_zero_o  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
